// File: rtl/wallace_mul_arbiter.sv
// Round-robin front end sharing one combinational 24x28 product unit between two requesters.
// Optional busy-cycle counter enabled with `define MUL_BUSY_CNT_EN.
module wallace_mul_arbiter #(
  parameter int unsigned LAT   = 2,
  parameter int unsigned CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [23:0] a0,
  input  logic [27:0] b0,
  input  logic [23:0] a1,
  input  logic [27:0] b1,
  output logic [1:0]  gnt,
  output logic [23:0] mul_a,
  output logic [27:0] mul_b,
  input  logic [51:0] mul_z,
  output logic [51:0] z,
  output logic        z_id,
  output logic        z_valid,
  input  logic        z_ready
`ifdef MUL_BUSY_CNT_EN
  ,output logic [CNT_W-1:0] busy_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  if (LAT < 1 || LAT > 15) begin : g_lat_chk
    $error("LAT must be in 1..15");
  end
  if (CNT_W < 1) begin : g_cnt_chk
    $error("CNT_W must be at least 1");
  end

  state_e      state_q, state_d;
  logic [23:0] mul_a_q, mul_a_d;
  logic [27:0] mul_b_q, mul_b_d;
  logic [51:0] z_q, z_d;
  logic        z_id_q, z_id_d;
  logic        z_valid_q, z_valid_d;
  logic        tag_q, tag_d;
  logic        last_q, last_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        sel_id;

  // On contention the requester that did not win last time goes next.
  assign sel_id = (req == 2'b11) ? ~last_q : req[1];

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      z_q       <= '0;
      z_id_q    <= 1'b0;
      z_valid_q <= 1'b0;
      tag_q     <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      z_q       <= z_d;
      z_id_q    <= z_id_d;
      z_valid_q <= z_valid_d;
      tag_q     <= tag_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
    end
  end

  // NOTE: every signal gets a hold default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    z_d       = z_q;
    z_id_d    = z_id_q;
    z_valid_d = z_valid_q;
    tag_d     = tag_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          mul_a_d = sel_id ? a1 : a0;
          mul_b_d = sel_id ? b1 : b0;
          tag_d   = sel_id;
          last_d  = sel_id;
          cnt_d   = 4'(LAT - 1);
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt_q == 4'd0) begin
          z_d       = mul_z;
          z_id_d    = tag_q;
          z_valid_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (z_valid_q && z_ready) begin
          z_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt = 2'b00;
    if (!rst && state_q == IDLE && |req) begin
      gnt = sel_id ? 2'b10 : 2'b01;
    end
  end

  assign mul_a   = mul_a_q;
  assign mul_b   = mul_b_q;
  assign z       = z_q;
  assign z_id    = z_id_q;
  assign z_valid = z_valid_q;

`ifdef MUL_BUSY_CNT_EN
  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;

  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (state_q == CALC && !(&busy_cnt_q)) begin
      busy_cnt_d = busy_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) busy_cnt_q <= '0;
    else     busy_cnt_q <= busy_cnt_d;
  end

  assign busy_cnt = busy_cnt_q;
`endif

endmodule

// File: tb/tb_wallace_mul_arbiter.sv
// Scoreboard bench for wallace_mul_arbiter with a behavioural stand-in for the shared multiplier.
module tb_wallace_mul_arbiter;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [23:0] a0, a1;
  logic [27:0] b0, b1;
  logic [1:0]  gnt;
  logic [23:0] mul_a;
  logic [27:0] mul_b;
  logic [51:0] mul_z;
  logic [51:0] z;
  logic        z_id;
  logic        z_valid;
  logic        z_ready;
`ifdef MUL_BUSY_CNT_EN
  logic [31:0] busy_cnt;
`endif

  wallace_mul_arbiter #(.LAT(LAT), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .req(req),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt(gnt), .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z),
    .z(z), .z_id(z_id), .z_valid(z_valid), .z_ready(z_ready)
`ifdef MUL_BUSY_CNT_EN
    , .busy_cnt(busy_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign mul_z = {28'd0, mul_a} * {24'd0, mul_b};

  typedef struct packed {
    logic        id;
    logic [51:0] z;
  } res_t;

  res_t exp_q[$];
  res_t got_q[$];
  bit   gnt_id_q[$];
  int   gnt_cyc_q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  res_t mon_r;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: push on accepted request, pop on output handshake.
  always @(negedge clk) begin
    if (!rst) begin
      check("gnt_not_both", 64'(gnt == 2'b11), 64'd0);
      if (|(req & gnt)) begin
        mon_r.id = gnt[1];
        mon_r.z  = gnt[1] ? {28'd0, a1} * {24'd0, b1} : {28'd0, a0} * {24'd0, b0};
        exp_q.push_back(mon_r);
        gnt_id_q.push_back(gnt[1]);
        gnt_cyc_q.push_back(cyc);
      end
      if (z_valid && z_ready) begin
        got_q.push_back({z_id, z});
        if (exp_q.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          mon_r = exp_q.pop_front();
          check("sb_z", z, mon_r.z);
          check("sb_id", z_id, mon_r.id);
        end
      end
    end
  end

  task automatic wait_grant(input string tag, input logic [1:0] exp_g);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (|(req & gnt)) break;
    end
    check(tag, gnt, exp_g);
  endtask

  task automatic wait_valid(input string tag, input int exp_lat);
    int n;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (z_valid) break;
    end
    check(tag, n, exp_lat);
  endtask

  task automatic run_op(input string tag, input bit id, input logic [23:0] a, input logic [27:0] b);
    @(posedge clk); #1;
    if (id) begin a1 = a; b1 = b; req = 2'b10; end
    else    begin a0 = a; b0 = b; req = 2'b01; end
    wait_grant({tag, "_gnt"}, id ? 2'b10 : 2'b01);
    @(posedge clk); #1;
    req = 2'b00;
    wait_valid({tag, "_lat"}, LAT + 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [51:0] hold_z;
    logic        hold_id;
    int          n0, g0;

    rst = 1'b1; req = 2'b01; z_ready = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    @(negedge clk);
    check("gnt_in_rst", gnt, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0; req = 2'b00;
    @(negedge clk);
    check("rst_z", z, 0);
    check("rst_z_id", z_id, 0);
    check("rst_z_valid", z_valid, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);

    // Max operands
    z_ready = 1'b1;
    run_op("max", 1'b0, 24'hffffff, 28'hfffffff);
    check("max_z", z, 52'hFFFFFEF000001);
    check("max_id", z_id, 0);
    check("max_mul_a", mul_a, 24'hffffff);

    // Contention from a fresh reset so requester 0 wins first
    do_reset();
    n0 = gnt_id_q.size();
    g0 = got_q.size();
    a0 = 24'd3; b0 = 28'd5; a1 = 24'd7; b1 = 28'd9; req = 2'b11;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (gnt_id_q.size() >= n0 + 4) break;
    end
    @(posedge clk); #1;
    req = 2'b00;
    check("cont_grants", gnt_id_q.size(), n0 + 4);
    if (gnt_id_q.size() >= n0 + 4) begin
      for (int k = 0; k < 4; k++) check("cont_alt_id", gnt_id_q[n0+k], k % 2);
      for (int k = 1; k < 4; k++) check("cont_spacing", gnt_cyc_q[n0+k] - gnt_cyc_q[n0+k-1], LAT + 2);
    end
    for (int i = 0; i < 40; i++) begin
      if (got_q.size() >= g0 + 4) break;
      @(negedge clk);
    end
    check("cont_results", got_q.size(), g0 + 4);
    if (got_q.size() >= g0 + 2) begin
      check("cont_first_z", got_q[g0].z, 52'd15);
      check("cont_first_id", got_q[g0].id, 0);
      check("cont_second_z", got_q[g0+1].z, 52'd63);
      check("cont_second_id", got_q[g0+1].id, 1);
    end

    // Backpressure with requester 1 waiting
    @(posedge clk); #1;
    z_ready = 1'b0;
    a0 = 24'd11; b0 = 28'd13; a1 = 24'd17; b1 = 28'd19; req = 2'b01;
    wait_grant("bp_gnt0", 2'b01);
    @(posedge clk); #1;
    req = 2'b10;
    wait_valid("bp_lat", LAT + 1);
    hold_z = z;
    hold_id = z_id;
    check("bp_z_value", hold_z, 52'd143);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_z", z, hold_z);
      check("bp_hold_id", z_id, hold_id);
      check("bp_hold_valid", z_valid, 1);
      check("bp_no_gnt", gnt, 2'b00);
    end
    @(posedge clk); #1;
    z_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_valid_drop", z_valid, 0);
    check("bp_z_retained", z, hold_z);
    check("bp_gnt1", gnt, 2'b10);
    @(posedge clk); #1;
    req = 2'b00;
    wait_valid("bp_lat1", LAT + 1);
    check("bp_z1", z, 52'd323);

    // Reset during the first CALC cycle discards the operation
    @(posedge clk); #1;
    a0 = 24'd21; b0 = 28'd23; req = 2'b01;
    wait_grant("mid_gnt", 2'b01);
    @(posedge clk); #1;
    req = 2'b00;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_mul_a", mul_a, 0);
    check("mid_mul_b", mul_b, 0);
    check("mid_z", z, 0);
    check("mid_z_id", z_id, 0);
    check("mid_gnt", gnt, 2'b00);
    for (int i = 0; i < LAT + 3; i++) begin
      check("mid_no_valid", z_valid, 0);
      @(negedge clk);
    end
    run_op("post_rst", 1'b0, 24'd25, 28'd27);
    check("post_rst_z", z, 52'd675);

`ifdef MUL_BUSY_CNT_EN
    do_reset();
    run_op("busy0", 1'b0, 24'd2, 28'd3);
    run_op("busy1", 1'b1, 24'd4, 28'd5);
    run_op("busy2", 1'b0, 24'd6, 28'd7);
    repeat (4) @(negedge clk);
    check("busy_cnt", busy_cnt, 3 * LAT);
`endif

    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
